// File: rtl/spi_flash_cmd_master.sv
// SPI flash command master: opcode, optional 24-bit address, optional dummy bytes, then N read bytes.
// Define SPI_FLASH_DUMMY_EN to add the dummy_len port and the DUMMY phase (FAST_READ support).
module spi_flash_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter int LEN_W   = 8,
  parameter int CS_IDLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [23:0]      addr,
  input  logic             addr_en,
  input  logic [LEN_W-1:0] rx_len,
`ifdef SPI_FLASH_DUMMY_EN
  input  logic [3:0]       dummy_len,
`endif
  output logic             busy,
  output logic             done,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] OPCODE   = 3'd2;
  localparam logic [2:0] ADDR     = 3'd3;
  localparam logic [2:0] DUMMY    = 3'd4;
  localparam logic [2:0] READ     = 3'd5;
  localparam logic [2:0] CS_HOLD  = 3'd6;
  localparam logic [2:0] GAP      = 3'd7;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             phase;
  logic [2:0]       bit_cnt;
  logic [6:0]       tx_sr;
  logic [6:0]       rx_sr;
  logic [23:0]      addr_q;
  logic             addr_en_q;
  logic [1:0]       addr_idx;
  logic [LEN_W-1:0] rd_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifdef SPI_FLASH_DUMMY_EN
  logic [3:0]       dmy_cnt;
`endif
  logic [2:0]       after_addr;
  logic [2:0]       byte_nxt;
  logic [7:0]       nxt_byte;

  assign tick = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));

  // Next phase once the current byte's last trailing edge has been issued.
  always_comb begin
    after_addr = (rd_cnt != '0) ? READ : CS_HOLD;
`ifdef SPI_FLASH_DUMMY_EN
    if (dmy_cnt != 4'd0) after_addr = DUMMY;
`endif
    byte_nxt = state;
    case (state)
      OPCODE:  byte_nxt = addr_en_q ? ADDR : after_addr;
      ADDR:    byte_nxt = (addr_idx == 2'd2) ? after_addr : ADDR;
`ifdef SPI_FLASH_DUMMY_EN
      DUMMY:   byte_nxt = (dmy_cnt > 4'd1) ? DUMMY : ((rd_cnt != '0) ? READ : CS_HOLD);
`endif
      READ:    byte_nxt = (rd_cnt > LEN_W'(1)) ? READ : CS_HOLD;
      default: byte_nxt = state;
    endcase
    nxt_byte = (byte_nxt == ADDR) ? addr_q[23:16] : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= 3'd0;
      tx_sr     <= 7'd0;
      rx_sr     <= 7'd0;
      addr_q    <= 24'd0;
      addr_en_q <= 1'b0;
      addr_idx  <= 2'd0;
      rd_cnt    <= '0;
      gap_cnt   <= '0;
`ifdef SPI_FLASH_DUMMY_EN
      dmy_cnt   <= 4'd0;
`endif
      sclk      <= CPOL;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;

      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CS_SETUP;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            mosi      <= opcode[7];
            tx_sr     <= opcode[6:0];
            addr_q    <= addr;
            addr_en_q <= addr_en;
            addr_idx  <= 2'd0;
            rd_cnt    <= rx_len;
`ifdef SPI_FLASH_DUMMY_EN
            dmy_cnt   <= dummy_len;
`endif
            bit_cnt   <= 3'd0;
            phase     <= 1'b0;
          end
        end

        CS_SETUP: begin
          if (tick) state <= OPCODE;
        end

        OPCODE, ADDR, DUMMY, READ: begin
          if (tick) begin
            if (!phase) begin
              // Leading edge: sample miso.
              sclk  <= ~CPOL;
              phase <= 1'b1;
              rx_sr <= {rx_sr[5:0], miso};
              if (state == READ && bit_cnt == 3'd7) begin
                rx_data  <= {rx_sr, miso};
                rx_valid <= 1'b1;
              end
            end else begin
              // Trailing edge: advance mosi, or pre-drive the next byte's MSB.
              sclk    <= CPOL;
              phase   <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= byte_nxt;
                tx_sr <= nxt_byte[6:0];
                mosi  <= nxt_byte[7];
                if (byte_nxt == ADDR) addr_q   <= {addr_q[15:0], 8'h00};
                if (state == ADDR)    addr_idx <= addr_idx + 2'd1;
                if (state == READ)    rd_cnt   <= rd_cnt - LEN_W'(1);
`ifdef SPI_FLASH_DUMMY_EN
                if (state == DUMMY)   dmy_cnt  <= dmy_cnt - 4'd1;
`endif
              end else begin
                tx_sr <= {tx_sr[5:0], 1'b0};
                mosi  <= tx_sr[6];
              end
            end
          end
        end

        CS_HOLD: begin
          if (tick) begin
            cs_n    <= 1'b1;
            done    <= 1'b1;
            gap_cnt <= '0;
            if (CS_IDLE == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_W'(CS_IDLE - 1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_master.sv
// Bench for spi_flash_cmd_master: a mode-0 and a mode-3 instance behind a lane select,
// a serial flash model on miso, and a byte-level reference of each command.
module tb_spi_flash_cmd_master;

  localparam int DIV0  = 2;
  localparam int DIV1  = 3;
  localparam int CSI   = 2;
  localparam int LEN_W = 8;
  localparam int TCLK  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic [23:0] addr = 24'h0;
  logic addr_en = 1'b0;
  logic [LEN_W-1:0] rx_len = '0;
`ifdef SPI_FLASH_DUMMY_EN
  logic [3:0] dummy_len = 4'd0;
`endif
  logic miso_m = 1'b0;

  wire busy0, done0, rxv0, sclk0, cs0, mosi0;
  wire busy1, done1, rxv1, sclk1, cs1, mosi1;
  wire [7:0] rxd0, rxd1;
  wire start0 = start & ~sel;
  wire start1 = start & sel;

  always #5 clk = ~clk;

  spi_flash_cmd_master #(.CLK_DIV(DIV0), .CPOL(1'b0), .LEN_W(LEN_W), .CS_IDLE(CSI)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .opcode(opcode), .addr(addr),
    .addr_en(addr_en), .rx_len(rx_len),
`ifdef SPI_FLASH_DUMMY_EN
    .dummy_len(dummy_len),
`endif
    .busy(busy0), .done(done0), .rx_valid(rxv0), .rx_data(rxd0),
    .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .miso(miso_m)
  );

  spi_flash_cmd_master #(.CLK_DIV(DIV1), .CPOL(1'b1), .LEN_W(LEN_W), .CS_IDLE(CSI)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .opcode(opcode), .addr(addr),
    .addr_en(addr_en), .rx_len(rx_len),
`ifdef SPI_FLASH_DUMMY_EN
    .dummy_len(dummy_len),
`endif
    .busy(busy1), .done(done1), .rx_valid(rxv1), .rx_data(rxd1),
    .sclk(sclk1), .cs_n(cs1), .mosi(mosi1), .miso(miso_m)
  );

  wire       m_sclk = sel ? sclk1 : sclk0;
  wire       m_cs_n = sel ? cs1 : cs0;
  wire       m_mosi = sel ? mosi1 : mosi0;
  wire       m_busy = sel ? busy1 : busy0;
  wire       m_done = sel ? done1 : done0;
  wire       m_rxv  = sel ? rxv1 : rxv0;
  wire [7:0] m_rxd  = sel ? rxd1 : rxd0;

  int n_cmp, n_bad;
  int n_lead, n_edge, n_done, n_csfall, n_stray, fidx;
  time t_cs_fall, t_cs_rise, t_busy_fall;
  logic [7:0] rx_got[$];
  logic [7:0] preset_q[$];
  bit mosi_got[$];
  bit fstream[$];

  // Flash model: bit k of the stream is presented after k trailing edges.
  always @(negedge m_cs_n) begin
    n_csfall++;
    t_cs_fall = $time;
    fidx = 0;
    miso_m = (fstream.size() > 0) ? fstream[0] : 1'b0;
  end
  always @(posedge m_cs_n) t_cs_rise = $time;
  always @(negedge m_busy) t_busy_fall = $time;

  always @(m_sclk) begin
    if (m_cs_n === 1'b0) begin
      n_edge++;
      if (m_sclk === ~sel) begin
        n_lead++;
        mosi_got.push_back(m_mosi);
      end else begin
        fidx++;
        miso_m = (fidx < fstream.size()) ? fstream[fidx] : 1'b0;
      end
    end else if (reset === 1'b1) begin
      n_stray++;
    end
  end

  always @(negedge clk) begin
    if (m_rxv === 1'b1) rx_got.push_back(m_rxd);
    if (m_done === 1'b1) n_done++;
  end

  task automatic pulse_start(input logic [7:0] op, input logic [23:0] a, input logic ae,
                             input logic [LEN_W-1:0] len);
    @(negedge clk);
    opcode = op;
    addr = a;
    addr_en = ae;
    rx_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_cmd(input bit lane, input logic [7:0] op, input logic [23:0] a, input bit ae,
                        input int len, input int nd, input bit inject, input string nm);
    int div, nhdr, budget;
    logic [7:0] hdr[$];
    logic [7:0] exp_rx[$];
    logic [7:0] b, ob, eb;
    time exp_t;
    div = lane ? DIV1 : DIV0;
    sel = lane;
    repeat (3) @(negedge clk);

    hdr = {};
    hdr.push_back(op);
    if (ae) begin
      hdr.push_back(a[23:16]);
      hdr.push_back(a[15:8]);
      hdr.push_back(a[7:0]);
    end
    for (int i = 0; i < nd; i++) hdr.push_back(8'h00);
    nhdr = hdr.size();
    fstream = {};
    for (int i = 0; i < nhdr * 8; i++) fstream.push_back($urandom_range(1) != 0);
    exp_rx = {};
    for (int i = 0; i < len; i++) begin
      b = (i < preset_q.size()) ? preset_q[i] : 8'($urandom);
      exp_rx.push_back(b);
      for (int k = 7; k >= 0; k--) fstream.push_back(b[k]);
    end
    preset_q = {};

    n_lead = 0; n_edge = 0; n_done = 0; n_csfall = 0; n_stray = 0;
    rx_got = {}; mosi_got = {};
    n_cmp++;
    if (m_sclk !== lane) begin
      n_bad++; $display("FAIL %s idle_sclk: got %b want %b", nm, m_sclk, lane);
    end
`ifdef SPI_FLASH_DUMMY_EN
    dummy_len = nd[3:0];
`endif
    pulse_start(op, a, ae, len[LEN_W-1:0]);
    n_cmp++;
    if (m_busy !== 1'b1) begin
      n_bad++; $display("FAIL %s busy_after_start: got %b want 1", nm, m_busy);
    end
    if (inject) begin
      repeat (20 * div) @(negedge clk);
      pulse_start(~op, ~a, 1'b1, 8'd5);
    end
    budget = 0;
    while (m_busy === 1'b1 && budget < 30000) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (budget >= 30000) begin
      n_bad++; $display("FAIL %s timeout: busy still %b after %0d cycles", nm, m_busy, budget);
    end
    repeat (4 * div) @(negedge clk);

    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL %s done_count: got %0d want 1", nm, n_done);
    end
    n_cmp++;
    if (n_csfall !== 1 || m_cs_n !== 1'b1) begin
      n_bad++; $display("FAIL %s cs_activations: got %0d (cs_n=%b) want 1 (cs_n=1)", nm, n_csfall, m_cs_n);
    end
    n_cmp++;
    if (n_lead !== 8 * (nhdr + len)) begin
      n_bad++; $display("FAIL %s lead_edges: got %0d want %0d", nm, n_lead, 8 * (nhdr + len));
    end
    n_cmp++;
    if (n_stray !== 0) begin
      n_bad++; $display("FAIL %s sclk_outside_cs: got %0d want 0", nm, n_stray);
    end
    for (int j = 0; j < nhdr + len; j++) begin
      ob = 8'h00;
      for (int k = 0; k < 8; k++)
        ob = {ob[6:0], (8 * j + k < mosi_got.size()) ? mosi_got[8 * j + k] : 1'b0};
      eb = (j < nhdr) ? hdr[j] : 8'h00;
      n_cmp++;
      if (ob !== eb) begin
        n_bad++; $display("FAIL %s mosi_byte%0d: got %h want %h", nm, j, ob, eb);
      end
    end
    n_cmp++;
    if (rx_got.size() !== len) begin
      n_bad++; $display("FAIL %s rx_count: got %0d want %0d", nm, rx_got.size(), len);
    end
    for (int j = 0; j < len && j < rx_got.size(); j++) begin
      n_cmp++;
      if (rx_got[j] !== exp_rx[j]) begin
        n_bad++; $display("FAIL %s rx_byte%0d: got %h want %h", nm, j, rx_got[j], exp_rx[j]);
      end
    end
    if (len > 0) begin
      n_cmp++;
      if (m_rxd !== exp_rx[len - 1]) begin
        n_bad++; $display("FAIL %s rx_data_hold: got %h want %h", nm, m_rxd, exp_rx[len - 1]);
      end
    end
    // cs_n low for setup tick + 16 ticks per byte + hold tick.
    exp_t = time'((16 * (nhdr + len) + 2) * div * TCLK);
    n_cmp++;
    if (t_cs_rise - t_cs_fall !== exp_t) begin
      n_bad++; $display("FAIL %s cs_low_time: got %0t want %0t", nm, t_cs_rise - t_cs_fall, exp_t);
    end
    exp_t = time'(CSI * div * TCLK);
    n_cmp++;
    if (t_busy_fall - t_cs_rise !== exp_t) begin
      n_bad++; $display("FAIL %s gap_time: got %0t want %0t", nm, t_busy_fall - t_cs_rise, exp_t);
    end
    n_cmp++;
    if (m_sclk !== lane || m_mosi !== 1'b0) begin
      n_bad++; $display("FAIL %s idle_pins: got sclk=%b mosi=%b want sclk=%b mosi=0", nm, m_sclk, m_mosi, lane);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sclk0 !== 1'b0 || sclk1 !== 1'b1) begin
      n_bad++; $display("FAIL reset_sclk: got %b/%b want 0/1", sclk0, sclk1);
    end
    n_cmp++;
    if (cs0 !== 1'b1 || cs1 !== 1'b1) begin
      n_bad++; $display("FAIL reset_cs_n: got %b/%b want 1/1", cs0, cs1);
    end
    n_cmp++;
    if (mosi0 !== 1'b0 || mosi1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_mosi: got %b/%b want 0/0", mosi0, mosi1);
    end
    n_cmp++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b/%b want 0/0", busy0, busy1);
    end
    n_cmp++;
    if (done0 !== 1'b0 || rxv0 !== 1'b0 || done1 !== 1'b0 || rxv1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got done=%b%b rx_valid=%b%b want 00 00", done0, done1, rxv0, rxv1);
    end
    n_cmp++;
    if (rxd0 !== 8'h00 || rxd1 !== 8'h00) begin
      n_bad++; $display("FAIL reset_rx_data: got %h/%h want 00/00", rxd0, rxd1);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rdid();
    preset_q = '{8'hEF, 8'h40, 8'h18};
    do_cmd(1'b0, 8'h9F, 24'h0, 1'b0, 3, 0, 1'b0, "rdid");
  endtask

  task automatic test_read_addr();
    do_cmd(1'b0, 8'h03, 24'h123456, 1'b1, 2, 0, 1'b0, "read_addr");
  endtask

  task automatic test_write_only();
    do_cmd(1'b0, 8'h06, 24'h0, 1'b0, 0, 0, 1'b0, "write_only");
  endtask

  task automatic test_mode3();
    preset_q = '{8'hEF, 8'h40, 8'h18};
    do_cmd(1'b1, 8'h9F, 24'h0, 1'b0, 3, 0, 1'b0, "mode3_rdid");
  endtask

  task automatic test_reset_mid();
    int budget;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    fstream = {};
    for (int i = 0; i < 80; i++) fstream.push_back($urandom_range(1) != 0);
    n_edge = 0; n_done = 0;
    pulse_start(8'h03, 24'h123456, 1'b1, 8'd2);
    budget = 0;
    while (n_edge < 10 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (budget >= 1000) begin
      n_bad++; $display("FAIL abort_wait_edges: got %0d edges want 10", n_edge);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (m_cs_n !== 1'b1 || m_sclk !== 1'b0 || m_busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_async: got cs_n=%b sclk=%b busy=%b want 1 0 0", m_cs_n, m_sclk, m_busy);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (n_done !== 0 || m_cs_n !== 1'b1) begin
      n_bad++; $display("FAIL abort_no_done: got done=%0d cs_n=%b want 0 1", n_done, m_cs_n);
    end
    do_cmd(1'b0, 8'h03, 24'hABCDEF, 1'b1, 2, 0, 1'b0, "after_abort");
  endtask

  task automatic test_start_while_busy();
    preset_q = '{8'hEF, 8'h40, 8'h18};
    do_cmd(1'b0, 8'h9F, 24'h0, 1'b0, 3, 0, 1'b1, "start_busy");
  endtask

`ifdef SPI_FLASH_DUMMY_EN
  task automatic test_fast_read();
    do_cmd(1'b0, 8'h0B, 24'h00A5C3, 1'b1, 2, 1, 1'b0, "fast_read");
    do_cmd(1'b1, 8'h0B, 24'h3C5A00, 1'b1, 1, 1, 1'b0, "fast_read_m3");
  endtask
`endif

  task automatic test_random();
    int nd;
    for (int i = 0; i < 12; i++) begin
      nd = 0;
`ifdef SPI_FLASH_DUMMY_EN
      nd = $urandom_range(2);
`endif
      do_cmd($urandom_range(1) != 0, 8'($urandom), 24'($urandom), $urandom_range(1) != 0,
             $urandom_range(4), nd, 1'b0, "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_rdid();
    test_read_addr();
    test_write_only();
    test_mode3();
    test_reset_mid();
    test_start_while_busy();
`ifdef SPI_FLASH_DUMMY_EN
    test_fast_read();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_cmd_master.md
Name: spi_flash_cmd_master

Overview:
- Parametrised successor to the fixed-function RDID SPI master.
- Issues one generic SPI-flash command per start pulse: 8-bit opcode, optional 24-bit address, then N read bytes streamed out one per byte.
- Sits between the system controller and the external serial flash pins; typical commands are RDID (0x9F), READ (0x03) and RDSR (0x05).
- Supports SPI mode 0 and mode 3 and a programmable SCLK divider.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period. Legal range is 1 or more.
- CPOL, 0: SCLK idle level. 0 selects mode 0, 1 selects mode 3 (CPHA always equals CPOL).
- LEN_W, 8: width of rx_len. The maximum read is 2^LEN_W-1 bytes.
- CS_IDLE, 2: minimum cs_n high time between commands, in SCLK half-periods.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request. Sampled only in IDLE.
- opcode  input  8  command byte. Latched when start is accepted.
- addr  input  24  address, sent MSB first. Latched when start is accepted.
- addr_en  input  1  1 sends the 3 address bytes after the opcode.
- rx_len  input  LEN_W  number of read bytes. Value 0 means write-only.
- busy  output  1  high from start acceptance until the end of the CS_IDLE gap.
- done  output  1  one-cycle pulse at the end of the command.
- rx_valid  output  1  one-cycle pulse per received byte.
- rx_data  output  8  received byte. Valid when rx_valid is high; holds its value otherwise.
- sclk  output  1  SPI clock.
- cs_n  output  1  chip select, active-low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset (reset low): state IDLE, sclk=CPOL, cs_n=1, mosi=0, busy=0, done=0, rx_valid=0, rx_data=0x00.
- Reset mid-command deasserts cs_n immediately. There is no partial done.
- Tick generator: half-period counter 0..CLK_DIV-1. A tick occurs when the counter wraps. The counter runs only while not in IDLE.
- start is accepted only in IDLE with busy=0.
  - Latch opcode, addr, addr_en and rx_len.
  - busy=1 on the next cycle.
  - start while busy is ignored.
- State IDLE: on start go to CS_SETUP.
- State CS_SETUP:
  - cs_n=0 and mosi=opcode[7] in the same cycle.
  - Wait 1 tick, then go to OPCODE.
- States OPCODE, ADDR and DUMMY: shift 8 bits per byte, MSB first.
  - Each bit spans 2 ticks: a leading edge, then a trailing edge.
  - Sample miso on the leading edge (rising in mode 0, falling in mode 3).
  - Update mosi on the trailing edge.
  - The first bit is pre-driven, so the last trailing edge loads the next byte's MSB.
- Byte ordering:
  - ADDR sends 3 bytes: addr[23:16], [15:8], [7:0]. It is skipped if addr_en=0.
  - After OPCODE/ADDR, go to DUMMY (see Optional Feature), else READ if rx_len>0, else CS_HOLD.
- State READ:
  - mosi=0.
  - After each 8th sample, rx_data takes the assembled byte and rx_valid pulses on the following clk.
  - The byte counter decrements. At 0 go to CS_HOLD.
- State CS_HOLD:
  - sclk stays at CPOL.
  - After 1 tick, cs_n=1 and done pulses for 1 cycle.
  - Then go to GAP.
- State GAP: wait CS_IDLE ticks with cs_n=1, then busy=0 and go to IDLE.
- sclk outside shift states: always CPOL. No glitches; sclk is driven from a register.
- Byte timing: one byte takes 16 ticks, i.e. 16*CLK_DIV clk cycles.
- Bit counter is 3 bits and wraps 7 to 0 per byte. The byte counter is LEN_W bits.

Optional Feature:
- Macro: SPI_FLASH_DUMMY_EN.
- Defined:
  - Adds input port dummy_len (4 bits), latched with start.
  - DUMMY state sends dummy_len bytes of 0x00 after the address and discards miso. 0 skips the state.
  - Supports FAST_READ (0x0B) with dummy_len=1.
- Undefined:
  - No dummy_len port.
  - DUMMY state is never entered (OPCODE/ADDR go directly to READ/CS_HOLD).

Test Plan:
1. RDID: CLK_DIV=2, CPOL=0, opcode=0x9F, addr_en=0, rx_len=3, flash model returns EF 40 18.
   - Expect rx_valid x3 with rx_data 0xEF, 0x40, 0x18.
   - Expect mosi pattern 10011111 on rising edges.
   - Expect 32 sclk rising edges while cs_n=0, then done, then busy low 2 ticks after cs_n rises.
2. READ with address: opcode=0x03, addr=0x123456, addr_en=1, rx_len=2.
   - Expect mosi bytes 03 12 34 56, then 2 bytes received.
   - Expect 48 rising edges in total.
3. Write-only: opcode=0x06, rx_len=0.
   - Expect exactly 8 sclk pulses, done, and no rx_valid.
4. Mode 3: CPOL=1, repeat scenario 1.
   - Expect sclk idle high, sampling on falling edges, identical rx_data.
5. Reset mid-command: drive reset low after the 10th sclk edge of scenario 2.
   - Expect cs_n=1, sclk=CPOL, busy=0 asynchronously, and no done.
   - Expect a subsequent start to run normally.
6. start while busy: pulse start again mid-RDID.
   - Expect it ignored: one done, 3 rx_valid.
   - With SPI_FLASH_DUMMY_EN: opcode=0x0B, dummy_len=1 gives 5 tx bytes before read data.
